multi_digit_display_7_segments: RTL

//  Sequential binary-to-N-digit 7-segment driver; parametrised successor to the two-digit score display.

---
 rtl/disp7_pkg.sv | 20 ++
 rtl/bcd_to_seg7.sv | 19 +
 rtl/multi_digit_display_7_segments.sv | 134 +++++++++++++
 3 files changed

// File: rtl/disp7_pkg.sv
// rtl/disp7_pkg.sv - shared segment constants and FSM state type for the 7-segment display driver
package disp7_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_RESET = 7'b1000000;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } disp7_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low 7-segment pattern
module bcd_to_seg7
    import disp7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Digits 0-9 map to their glyphs; codes 10-15 are shown blank
    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nibble == 4'(i)) begin
                seg = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/multi_digit_display_7_segments.sv
// rtl/multi_digit_display_7_segments.sv - iterative binary-to-BCD 7-segment driver (option: DISP7_LZ_BLANK_EN)
module multi_digit_display_7_segments
    import disp7_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam longint unsigned MAX_SHOWN = longint'(10) ** DIGITS - 1;

    disp7_state_t          state, state_nxt;
    logic [WIDTH-1:0]      bin_q;
    logic [BW-1:0]         bcd_q;
    logic [BW-1:0]         bcd_adj;
    logic [BW+WIDTH-1:0]   shifted;
    logic [CW-1:0]         cnt_q;
    logic                  ovf_q;
    logic [7*DIGITS-1:0]   dec_seg;
    logic [7*DIGITS-1:0]   seg_nxt;

    assign in_ready = (state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: SHIFT runs until the last bit has been consumed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: bump every nibble >= 5 by 3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            bcd_to_seg7 u_dec (
                .nibble (bcd_q[4*g +: 4]),
                .seg    (dec_seg[7*g +: 7])
            );
        end
    endgenerate

`ifdef DISP7_LZ_BLANK_EN
    logic lead;
`endif

    // Final display image: dashes on overflow, otherwise decoded digits (optionally zero-blanked)
    always_comb begin
        seg_nxt = dec_seg;
`ifdef DISP7_LZ_BLANK_EN
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead) begin
                seg_nxt[7*k +: 7] = SEG_BLANK;
            end
        end
`endif
        if (ovf_q) begin
            seg_nxt = {DIGITS{SEG_DASH}};
        end
    end

    // Datapath: capture, shift, then publish the result in one registered step
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            seg      <= {DIGITS{SEG_RESET}};
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q <= in_value;
                        bcd_q <= '0;
                        cnt_q <= CW'(WIDTH);
                        ovf_q <= (64'(in_value) > MAX_SHOWN);
                    end
                end
                SHIFT: begin
                    bcd_q <= shifted[BW+WIDTH-1 -: BW];
                    bin_q <= shifted[WIDTH-1:0];
                    cnt_q <= cnt_q - CW'(1);
                end
                UPDATE: begin
                    seg      <= seg_nxt;
                    overflow <= ovf_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
